sap_control_sequencer: RTL and testbench
========================================

# sap_control_sequencer

Control sequencer for the SAP-U datapath. Generates the per-T-state load/enable/select strobes that drive the 4-bit register slices (PC, MAR, IR, A, B, OUT), the RAM output enable and the ALU, from a 6-state ring counter and the IR opcode nibble. It is the only source of register `load` strobes in the CPU; registers capture on the rising `clk` edge that ends the T-state in which their strobe is high.

## Interface
Parameters:
- none; opcode map and T-state count are fixed by the SAP-1 instruction set.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high; sampled on the rising `clk` edge
- `run`  in  1  1 = advance one T-state per clock; 0 = freeze state, force strobes low
- `opcode`  in  4  IR[7:4]; must be valid from T4 through the end of the instruction
- `tstate`  out  3  current T-state, 1..6 (T1..T6)
- `halted`  out  1  sticky halt flag
- `pc_inc`, `pc_out`, `mar_load`, `ram_out`, `ir_load`, `ir_out`  out  1 each  datapath strobes
- `a_load`, `a_out`, `b_load`, `alu_sub`, `alu_out`, `out_load`  out  1 each  datapath strobes

## Operation
- Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111; all others are NOP.
- Fetch, all opcodes:
  - T1: `pc_out`, `mar_load`
  - T2: `pc_inc`
  - T3: `ram_out`, `ir_load`
- Execute:
  - LDA: T4 `ir_out`,`mar_load`; T5 `ram_out`,`a_load`; T6 none.
  - ADD: T4 `ir_out`,`mar_load`; T5 `ram_out`,`b_load`; T6 `alu_out`,`a_load`.
  - SUB: as ADD, plus `alu_sub` in T6.
  - OUT: T4 `a_out`,`out_load`; T5, T6 none.
  - NOP: T4–T6 none.
  - HLT: on the edge ending T4, `halted` sets. `tstate` then stays at 4 and all strobes stay 0 until reset.
- Strobes are a combinational decode of registered `tstate` and `opcode`, gated to 0 whenever `reset`=1, `run`=0 or `halted`=1.
- At most one `*_out` strobe is high in any T-state (single bus driver). Verification checks this on every cycle.

## Timing
- Reset: on the first rising edge with `reset`=1, `tstate`=1 and `halted`=0. All strobes read 0 while `reset` is high, and T1 strobes appear in the cycle after `reset` falls.
- Reset mid-instruction or while halted: next state is T1 and `halted` clears. Reset has priority over `run` and halt.
- Advance: T1→T2→…→T6→T1, one step per clock while `run`=1.
- `run`=0: `tstate` holds and no strobes are asserted. Resuming with `run`=1 re-issues the held T-state's strobes.
- Latency, default build: 6 clocks per instruction, regardless of opcode.
- `opcode` is sampled combinationally during T4–T6 only and ignored in T1–T3.
- HLT: `halted` rises 1 clock after T4 is entered (registered).

## Configuration
- `SAP_SEQ_EARLY_END_EN`: when defined, an instruction returns to T1 immediately after its last non-empty T-state.
  - Cycle lengths: LDA 5, ADD 6, SUB 6, OUT 4, NOP 4.
  - NOP still spends T4, because the opcode is unknown before T4.
  - HLT behaviour is unchanged.
- Not defined: every instruction runs all of T1–T6.

## Test plan
- Reset/run: assert `reset` 2 clocks, then release with `run`=1. Expect strobes all 0 during reset; `tstate` 1,2,3,4,5,6,1 on successive clocks; T1 shows only `pc_out`+`mar_load`.
- LDA then ADD: `opcode`=0000, then 0001. Expect LDA T5 `ram_out`+`a_load`, ADD T5 `ram_out`+`b_load`, ADD T6 `alu_out`+`a_load`, and `alu_sub`=0 throughout.
- SUB, OUT, NOP: `opcode`=0010 gives `alu_sub`=1 only in T6. 1110 gives T4 `a_out`+`out_load`. 0101 gives T4–T6 all strobes 0. With `SAP_SEQ_EARLY_END_EN`, OUT and NOP each return to T1 after 4 clocks and LDA after 5.
- HLT: `opcode`=1111. Expect `halted`=1 one clock after T4 and `tstate` frozen at 4 with zero strobes for 20 clocks. `reset` then gives `tstate`=1, `halted`=0.
- `run` gating: drop `run` during ADD T5 for 3 clocks. Expect `tstate` held at 5, `b_load`=0 while `run` is low, then `b_load`=1 for exactly 1 clock after resume.
- Reset mid-instruction: assert `reset` in SUB T5. Expect `tstate`=1 on the next edge, no `a_load` issued, and normal fetch afterwards.

Source files
------------

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: 6-state T-state ring plus opcode decode into datapath strobes.
// Optional SAP_SEQ_EARLY_END_EN: return to T1 right after an instruction's last non-empty T-state.
module sap_control_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic [2:0] tstate,
  output logic       halted,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       out_load
);

  typedef enum logic [2:0] {
    T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
  } tstate_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  tstate_e r_state;
  tstate_e w_state_next;
  tstate_e w_last_state;
  logic    r_halted;
  logic    w_halted_next;
  logic    w_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= T1;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_halted <= w_halted_next;
    end
  end

  // Final T-state of the current instruction; only meaningful from T4 on.
  always_comb begin
    w_last_state = T6;
`ifdef SAP_SEQ_EARLY_END_EN
    case (opcode)
      OP_LDA:         w_last_state = T5;
      OP_ADD, OP_SUB: w_last_state = T6;
      OP_HLT:         w_last_state = T6;
      default:        w_last_state = T4;
    endcase
`endif
  end

  always_comb begin
    w_state_next  = r_state;
    w_halted_next = r_halted;
    if (!r_halted && run) begin
      if (r_state == T4 && opcode == OP_HLT) begin
        w_halted_next = 1'b1;
      end else if (r_state == T6 || (r_state >= T4 && r_state == w_last_state)) begin
        w_state_next = T1;
      end else begin
        w_state_next = tstate_e'(r_state + 3'd1);
      end
    end
  end

  assign w_enable = !reset && run && !r_halted;
  assign tstate   = r_state;
  assign halted   = r_halted;

  always_comb begin
    pc_inc   = 1'b0;
    pc_out   = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_sub  = 1'b0;
    alu_out  = 1'b0;
    out_load = 1'b0;
    if (w_enable) begin
      case (r_state)
        T1: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
          end else if (opcode == OP_OUT) begin
            a_out    = 1'b1;
            out_load = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ram_out = 1'b1;
            a_load  = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ram_out = 1'b1;
            b_load  = 1'b1;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out = 1'b1;
            a_load  = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Self-checking bench for sap_control_sequencer: directed scenarios plus randomized run against a T-state model.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic [2:0] tstate;
  logic       halted;
  logic       pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_sub, alu_out, out_load;
  logic [11:0] strobes;

  int total = 0;
  int bad = 0;

  localparam logic [11:0] S_PCI = 12'h800, S_PCO = 12'h400, S_MAR = 12'h200, S_RAM = 12'h100;
  localparam logic [11:0] S_IRL = 12'h080, S_IRO = 12'h040, S_AL = 12'h020, S_AO = 12'h010;
  localparam logic [11:0] S_BL = 12'h008, S_SUB = 12'h004, S_ALU = 12'h002, S_OUTL = 12'h001;

  sap_control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .tstate(tstate), .halted(halted),
    .pc_inc(pc_inc), .pc_out(pc_out), .mar_load(mar_load), .ram_out(ram_out),
    .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load), .a_out(a_out),
    .b_load(b_load), .alu_sub(alu_sub), .alu_out(alu_out), .out_load(out_load)
  );

  assign strobes = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
                    a_load, a_out, b_load, alu_sub, alu_out, out_load};

  always #5 clk = ~clk;

  // Instruction strobe table, ungated.
  function automatic logic [11:0] exp_strobes(input int t, input logic [3:0] op);
    logic [11:0] s;
    s = 12'h000;
    case (t)
      1: s = S_PCO | S_MAR;
      2: s = S_PCI;
      3: s = S_RAM | S_IRL;
      4: if (op == 4'h0 || op == 4'h1 || op == 4'h2) s = S_IRO | S_MAR;
         else if (op == 4'hE) s = S_AO | S_OUTL;
      5: if (op == 4'h0) s = S_RAM | S_AL;
         else if (op == 4'h1 || op == 4'h2) s = S_RAM | S_BL;
      6: if (op == 4'h1) s = S_ALU | S_AL;
         else if (op == 4'h2) s = S_ALU | S_AL | S_SUB;
      default: s = 12'h000;
    endcase
    return s;
  endfunction

  function automatic int ilen(input logic [3:0] op);
`ifdef SAP_SEQ_EARLY_END_EN
    case (op)
      4'h0: return 5;
      4'h1, 4'h2, 4'hF: return 6;
      default: return 4;
    endcase
`else
    return (op == op) ? 6 : 6;
`endif
  endfunction

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // Single bus driver, every cycle.
  always @(negedge clk) begin
    total++;
    if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
      bad++;
      $display("FAIL bus_driver t=%0d outs=%b required at most one high", tstate,
               {pc_out, ram_out, ir_out, a_out, alu_out});
    end
  end

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; opcode = 4'h1;
    for (int c = 0; c < 2; c++) begin
      clk_step();
      total++;
      if (tstate !== 3'd1 || halted !== 1'b0) begin
        bad++;
        $display("FAIL reset_state tstate=%0d halted=%b required 1/0", tstate, halted);
      end
      total++;
      if (strobes !== 12'h000) begin
        bad++;
        $display("FAIL reset_strobes got=%h required=000", strobes);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (strobes !== (S_PCO | S_MAR)) begin
      bad++;
      $display("FAIL reset_t1_strobes got=%h required=%h", strobes, S_PCO | S_MAR);
    end
    for (int i = 2; i <= 7; i++) begin
      clk_step();
      total++;
      if (tstate !== 3'((i == 7) ? 1 : i)) begin
        bad++;
        $display("FAIL reset_ring tstate=%0d required=%0d", tstate, (i == 7) ? 1 : i);
      end
    end
    $display("test_reset: ring 1..6,1 checked");
  endtask

  // Runs one complete instruction from T1, checking every T-state.
  task automatic run_instr(input logic [3:0] op, input string name);
    opcode = op;
    for (int k = 1; k <= ilen(op); k++) begin
      #1;
      total++;
      if (tstate !== 3'(k)) begin
        bad++;
        $display("FAIL %s_tstate got=%0d required=%0d", name, tstate, k);
      end
      total++;
      if (strobes !== exp_strobes(k, op)) begin
        bad++;
        $display("FAIL %s_T%0d_strobes got=%h required=%h", name, k, strobes, exp_strobes(k, op));
      end
      clk_step();
    end
    total++;
    if (tstate !== 3'd1) begin
      bad++;
      $display("FAIL %s_wrap tstate=%0d required=1", name, tstate);
    end
    $display("instr %s op=%b len=%0d checked", name, op, ilen(op));
  endtask

  task automatic test_lda_add();
    run_instr(4'h0, "LDA");
    run_instr(4'h1, "ADD");
  endtask

  task automatic test_sub_out_nop();
    run_instr(4'h2, "SUB");
    run_instr(4'hE, "OUT");
    run_instr(4'h5, "NOP");
  endtask

  task automatic test_run_gating();
    opcode = 4'h1;
    for (int k = 1; k <= 4; k++) clk_step();
    run = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (tstate !== 3'd5 || strobes !== 12'h000) begin
        bad++;
        $display("FAIL run_low tstate=%0d strobes=%h required 5/000", tstate, strobes);
      end
      clk_step();
    end
    run = 1'b1;
    #1;
    total++;
    if (tstate !== 3'd5 || b_load !== 1'b1) begin
      bad++;
      $display("FAIL run_resume tstate=%0d b_load=%b required 5/1", tstate, b_load);
    end
    clk_step();
    total++;
    if (tstate !== 3'd6 || b_load !== 1'b0) begin
      bad++;
      $display("FAIL run_after tstate=%0d b_load=%b required 6/0", tstate, b_load);
    end
    clk_step();
    $display("test_run_gating: ADD T5 held 3 clocks");
  endtask

  task automatic test_reset_mid();
    opcode = 4'h2;
    for (int k = 1; k <= 4; k++) clk_step();
    reset = 1'b1;
    #1;
    total++;
    if (strobes !== 12'h000) begin
      bad++;
      $display("FAIL reset_mid_strobes got=%h required=000", strobes);
    end
    clk_step();
    reset = 1'b0;
    #1;
    total++;
    if (tstate !== 3'd1 || a_load !== 1'b0 || strobes !== (S_PCO | S_MAR)) begin
      bad++;
      $display("FAIL reset_mid_t1 tstate=%0d strobes=%h required 1/%h", tstate, strobes, S_PCO | S_MAR);
    end
    run_instr(4'h0, "LDA_after_reset");
  endtask

  task automatic test_hlt();
    opcode = 4'hF;
    for (int k = 1; k <= 3; k++) clk_step();
    total++;
    if (tstate !== 3'd4 || halted !== 1'b0 || strobes !== 12'h000) begin
      bad++;
      $display("FAIL hlt_t4 tstate=%0d halted=%b strobes=%h required 4/0/000", tstate, halted, strobes);
    end
    for (int c = 0; c < 21; c++) begin
      clk_step();
      total++;
      if (tstate !== 3'd4 || halted !== 1'b1 || strobes !== 12'h000) begin
        bad++;
        $display("FAIL hlt_frozen c=%0d tstate=%0d halted=%b strobes=%h required 4/1/000",
                 c, tstate, halted, strobes);
      end
    end
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    total++;
    if (tstate !== 3'd1 || halted !== 1'b0) begin
      bad++;
      $display("FAIL hlt_reset tstate=%0d halted=%b required 1/0", tstate, halted);
    end
    $display("test_hlt: halted 21 clocks then reset");
  endtask

  task automatic test_random();
    int t_m = 1;
    bit h_m = 1'b0;
    logic [11:0] e;
    for (int c = 0; c < 600; c++) begin
      reset = h_m ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      run = ($urandom_range(0, 7) != 0);
      if (t_m <= 3) opcode = 4'($urandom_range(0, 15));
      #1;
      e = (reset || !run || h_m) ? 12'h000 : exp_strobes(t_m, opcode);
      total++;
      if (tstate !== 3'(t_m) || halted !== h_m || strobes !== e) begin
        bad++;
        $display("FAIL random c=%0d op=%b tstate=%0d halted=%b strobes=%h required %0d/%b/%h",
                 c, opcode, tstate, halted, strobes, t_m, h_m, e);
      end
      @(posedge clk);
      if (reset) begin
        t_m = 1; h_m = 1'b0;
      end else if (!h_m && run) begin
        if (t_m == 4 && opcode == 4'hF) h_m = 1'b1;
        else if (t_m >= ilen(opcode)) t_m = 1;
        else t_m++;
      end
      #1;
    end
    reset = 1'b0; run = 1'b1;
    $display("test_random: 600 cycles checked");
  endtask

  initial begin
    test_reset();
    test_lda_add();
    test_sub_out_nop();
    test_run_gating();
    test_reset_mid();
    test_hlt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
